// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single rf_32 write port between the ALU
// writeback (port a) and the load writeback (port m). Each port has a
// one-entry holding buffer; arbitration is round-robin, except that the
// older buffer wins when both target the same register. The pending
// vector flags every register with a buffered, not-yet-granted write.
module rf_write_arbiter #(
  parameter int REG_SIZE     = 32,
  parameter int INDEX_SIZE   = 5,
  parameter int REGFILE_SIZE = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic [INDEX_SIZE-1:0]   a_addr,
  input  logic [REG_SIZE-1:0]     a_data,
  output logic                    a_ready,
  input  logic                    m_valid,
  input  logic [INDEX_SIZE-1:0]   m_addr,
  input  logic [REG_SIZE-1:0]     m_data,
  output logic                    m_ready,
  input  logic                    hold,
  output logic                    write_enabled,
  output logic [INDEX_SIZE-1:0]   write_addr,
  output logic [REG_SIZE-1:0]     write_data,
  output logic [REGFILE_SIZE-1:0] pending
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_M = 1'b1
  } grant_e;

  // Holding buffers
  logic                  r_a_full;
  logic [INDEX_SIZE-1:0] r_a_addr;
  logic [REG_SIZE-1:0]   r_a_data;
  logic                  r_m_full;
  logic [INDEX_SIZE-1:0] r_m_addr;
  logic [REG_SIZE-1:0]   r_m_data;

  // Arbitration state
  grant_e r_last_grant;
  logic   r_a_older;

  logic w_gnt_a;
  logic w_gnt_m;
  logic w_a_load;
  logic w_m_load;
  logic w_a_stay;
  logic w_m_stay;

  // Grant selection; reset suppresses grants so no buffered write leaks
  // into the register file on the cycle its buffer is being discarded.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_m = 1'b0;
    if (!hold && !reset) begin
      if (r_a_full && r_m_full) begin
        if (r_a_addr == r_m_addr) begin
          w_gnt_a = r_a_older;
          w_gnt_m = !r_a_older;
        end else begin
          w_gnt_a = (r_last_grant == GRANT_M);
          w_gnt_m = (r_last_grant == GRANT_A);
        end
      end else begin
        w_gnt_a = r_a_full;
        w_gnt_m = r_m_full;
      end
    end
  end

  assign a_ready = !r_a_full || w_gnt_a;
  assign m_ready = !r_m_full || w_gnt_m;

  // Register 0 requests complete the handshake but never occupy a buffer.
  assign w_a_load = a_valid && a_ready && (a_addr != '0);
  assign w_m_load = m_valid && m_ready && (m_addr != '0);

  // A buffer "stays" when it is full and not drained at this edge.
  assign w_a_stay = r_a_full && !w_gnt_a;
  assign w_m_stay = r_m_full && !w_gnt_m;

  // Write port to rf_32, driven from the granted buffer.
  always_comb begin
    write_enabled = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    if (w_gnt_a) begin
      write_enabled = 1'b1;
      write_addr    = r_a_addr;
      write_data    = r_a_data;
    end else if (w_gnt_m) begin
      write_enabled = 1'b1;
      write_addr    = r_m_addr;
      write_data    = r_m_data;
    end
  end

  // Pending-write scoreboard from buffer state.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < REGFILE_SIZE; i++) begin
      pending[i] = (r_a_full && (r_a_addr == i[INDEX_SIZE-1:0])) ||
                   (r_m_full && (r_m_addr == i[INDEX_SIZE-1:0]));
    end
  end

  // Buffer fill/drain, round-robin pointer and relative age tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_full     <= 1'b0;
      r_a_addr     <= '0;
      r_a_data     <= '0;
      r_m_full     <= 1'b0;
      r_m_addr     <= '0;
      r_m_data     <= '0;
      r_last_grant <= GRANT_M;
      r_a_older    <= 1'b0;
    end else begin
      if (w_a_load) begin
        r_a_full <= 1'b1;
        r_a_addr <= a_addr;
        r_a_data <= a_data;
      end else if (w_gnt_a) begin
        r_a_full <= 1'b0;
      end

      if (w_m_load) begin
        r_m_full <= 1'b1;
        r_m_addr <= m_addr;
        r_m_data <= m_data;
      end else if (w_gnt_m) begin
        r_m_full <= 1'b0;
      end

      if (w_gnt_a) begin
        r_last_grant <= GRANT_A;
      end else if (w_gnt_m) begin
        r_last_grant <= GRANT_M;
      end

      // Simultaneous loads treat a as older; otherwise the newcomer is younger.
      if (w_a_load && w_m_load) begin
        r_a_older <= 1'b1;
      end else if (w_a_load && w_m_stay) begin
        r_a_older <= 1'b0;
      end else if (w_m_load && w_a_stay) begin
        r_a_older <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios plus randomized traffic, each
// cycle compared against a sequence-stamped buffer model of the arbiter.
module tb_rf_write_arbiter;

  localparam int RS = 32;
  localparam int IS = 5;
  localparam int NR = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0;
  logic [IS-1:0] a_addr = '0;
  logic [RS-1:0] a_data = '0;
  logic          a_ready;
  logic          m_valid = 1'b0;
  logic [IS-1:0] m_addr = '0;
  logic [RS-1:0] m_data = '0;
  logic          m_ready;
  logic          hold = 1'b0;
  logic          write_enabled;
  logic [IS-1:0] write_addr;
  logic [RS-1:0] write_data;
  logic [NR-1:0] pending;

  always #5 clock = ~clock;

  rf_write_arbiter #(
    .REG_SIZE    (RS),
    .INDEX_SIZE  (IS),
    .REGFILE_SIZE(NR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .m_valid      (m_valid),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .hold         (hold),
    .write_enabled(write_enabled),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending      (pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: index 0 = port a, 1 = port m; age is an acceptance sequence number.
  bit          mf[2];
  int unsigned maddr[2];
  logic [31:0] mdata[2];
  int unsigned mstamp[2];
  int unsigned seq = 0;
  int          last = 1;
  logic [31:0] ref_rf[32];
  logic [31:0] seen_rf[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at negedge, then advance the model.
  task automatic step(input bit rst, input bit h,
                      input bit av, input int aa, input logic [31:0] ad,
                      input bit mv, input int ma, input logic [31:0] md,
                      input bit chk);
    int          g;
    bit          vld[2];
    bit          rdy[2];
    int          adr[2];
    logic [31:0] dat[2];
    logic [31:0] e_pend;
    @(posedge clock);
    #1;
    reset = rst; hold = h;
    a_valid = av; a_addr = IS'(aa); a_data = ad;
    m_valid = mv; m_addr = IS'(ma); m_data = md;
    vld[0] = av; adr[0] = aa; dat[0] = ad;
    vld[1] = mv; adr[1] = ma; dat[1] = md;
    g = -1;
    if (!h && !rst) begin
      if (mf[0] && mf[1]) begin
        if (maddr[0] == maddr[1]) g = (mstamp[0] < mstamp[1]) ? 0 : 1;
        else g = 1 - last;
      end else if (mf[0]) g = 0;
      else if (mf[1]) g = 1;
    end
    e_pend = '0;
    for (int p = 0; p < 2; p++) if (mf[p]) e_pend[maddr[p]] = 1'b1;
    for (int p = 0; p < 2; p++) rdy[p] = !mf[p] || (g == p);
    @(negedge clock);
    if (write_enabled === 1'b1) seen_rf[write_addr] = write_data;
    if (chk) begin
      check("write_enabled", 32'(write_enabled), 32'(g >= 0));
      check("write_addr", 32'(write_addr), (g >= 0) ? maddr[g] : 32'd0);
      check("write_data", write_data, (g >= 0) ? mdata[g] : 32'd0);
      check("pending", pending, e_pend);
      check("a_ready", 32'(a_ready), 32'(rdy[0]));
      check("m_ready", 32'(m_ready), 32'(rdy[1]));
    end
    if (rst) begin
      mf[0] = 1'b0; mf[1] = 1'b0; last = 1;
    end else begin
      if (g >= 0) begin
        ref_rf[maddr[g]] = mdata[g];
        mf[g] = 1'b0;
        last = g;
      end
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && rdy[p] && adr[p] != 0) begin
          mf[p] = 1'b1; maddr[p] = adr[p]; mdata[p] = dat[p];
          mstamp[p] = seq; seq++;
        end
      end
    end
  endtask

  task automatic idle(input bit h);
    step(1'b0, h, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1);
  endtask

  initial begin
    bit r, h, av, mv;
    int aa, ma;
    for (int i = 0; i < 32; i++) begin ref_rf[i] = '0; seen_rf[i] = '0; end
    mf[0] = 1'b0; mf[1] = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0);
    idle(1'b0);
    check("rst_we", 32'(write_enabled), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ready", {30'd0, a_ready, m_ready}, 32'd3);

    // Single write
    step(1'b0, 1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'd0, 1'b1);
    idle(1'b0);
    check("single_we", 32'(write_enabled), 32'd1);
    check("single_addr", 32'(write_addr), 32'd5);
    check("single_data", write_data, 32'hDEADBEEF);
    check("single_pending", pending, 32'h20);
    idle(1'b0);
    check("single_we_after", 32'(write_enabled), 32'd0);
    check("single_pending_after", pending, 32'd0);

    // Contention, different registers, from reset
    do_reset();
    step(1'b0, 1'b0, 1'b1, 3, 32'h11, 1'b1, 7, 32'h22, 1'b1);
    idle(1'b0);
    check("cont_first", {27'd0, write_addr}, 32'd3);
    idle(1'b0);
    check("cont_second", {27'd0, write_addr}, 32'd7);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 10, 32'(i), 1'b1, 20, 32'(100 + i), 1'b1);
      if (i >= 1) begin
        check("alt_addr", {27'd0, write_addr}, (i % 2 == 1) ? 32'd10 : 32'd20);
        check("alt_ready", 32'(a_ready || m_ready), 32'd1);
      end
    end
    idle(1'b0); idle(1'b0);

    // Same-register ordering under hold
    step(1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b1, 9, 32'hAA, 1'b1);
    step(1'b0, 1'b1, 1'b1, 9, 32'hBB, 1'b0, 0, 32'd0, 1'b1);
    idle(1'b1);
    check("same_hold_we", 32'(write_enabled), 32'd0);
    check("same_hold_pending", pending, 32'h200);
    idle(1'b0);
    check("same_first", write_data, 32'hAA);
    idle(1'b0);
    check("same_second", write_data, 32'hBB);
    check("same_reg9", seen_rf[9], 32'hBB);

    // Register 0
    step(1'b0, 1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 32'd0, 1'b1);
    check("r0_ready", 32'(a_ready), 32'd1);
    idle(1'b0);
    check("r0_we", 32'(write_enabled), 32'd0);
    check("r0_pending", 32'(pending[0]), 32'd0);

    // Hold / backpressure with different registers
    step(1'b0, 1'b1, 1'b1, 4, 32'h44, 1'b1, 6, 32'h66, 1'b1);
    idle(1'b1);
    check("hold_ready", {30'd0, a_ready, m_ready}, 32'd0);
    check("hold_we", 32'(write_enabled), 32'd0);
    check("hold_pending", pending, 32'h50);
    idle(1'b0);
    check("release_we1", 32'(write_enabled), 32'd1);
    idle(1'b0);
    check("release_we2", 32'(write_enabled), 32'd1);

    // Reset mid-operation
    step(1'b0, 1'b1, 1'b1, 12, 32'h1212, 1'b1, 13, 32'h1313, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1);
    check("rst_mid_we", 32'(write_enabled), 32'd0);
    idle(1'b0);
    check("rst_mid_pending", pending, 32'd0);
    check("rst_mid_ready", {30'd0, a_ready, m_ready}, 32'd3);
    check("rst_mid_we2", 32'(write_enabled), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 7) == 0);
      av = ($urandom_range(0, 9) < 6);
      mv = ($urandom_range(0, 9) < 6);
      aa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      ma = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      step(r, h, av, aa, $urandom, mv, ma, $urandom, 1'b1);
    end
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Register file contents seen on the write port match the model
    for (int i = 0; i < 32; i++) check("rf_contents", seen_rf[i], ref_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
